// File: rtl/lsu_byte_bridge.sv
// Byte-serialising bridge: one core load/store becomes 1..8 little-endian byte
// beats on the memory channel, followed by a single extended response.
module lsu_byte_bridge #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_mode,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_w_data,
    input  logic              mem_r_data_valid,
    input  logic [7:0]        mem_r_data,
    input  logic              mem_invalid_addr
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t      state;
    logic        we;
    logic        sgn;
    logic [1:0]  size;
    logic [2:0]  cnt;
    logic [63:0] wbuf;
    logic [63:0] rbuf;
    logic [63:0] rbuf_next;
    logic        last;

    assign last = (cnt == 3'((4'd1 << size) - 4'd1));

    // Read buffer including the byte returned by the beat completing this cycle.
    always_comb begin
        rbuf_next = rbuf;
        if (!we && mem_r_data_valid)
            rbuf_next[{cnt, 3'b000} +: 8] = mem_r_data;
    end

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                           input logic s);
        case (sz)
            2'd0:    return {{56{s & d[7]}}, d[7:0]};
            2'd1:    return {{48{s & d[15]}}, d[15:0]};
            2'd2:    return {{32{s & d[31]}}, d[31:0]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we         <= 1'b0;
            sgn        <= 1'b0;
            size       <= 2'd0;
            cnt        <= 3'd0;
            wbuf       <= 64'd0;
            rbuf       <= 64'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_mode   <= 1'b0;
            mem_addr   <= '0;
            mem_w_data <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state      <= XFER;
                        we         <= req_we;
                        sgn        <= req_signed;
                        size       <= req_size;
                        cnt        <= 3'd0;
                        wbuf       <= req_wdata;
                        rbuf       <= 64'd0;
                        req_ready  <= 1'b0;
                        mem_valid  <= 1'b1;
                        mem_mode   <= req_we;
                        mem_addr   <= req_addr;
                        mem_w_data <= req_wdata[7:0];
                    end
                end
                XFER: begin
                    // Memory-side outputs only move on a completed beat, so a stall holds them.
                    if (mem_ready) begin
                        if (mem_invalid_addr || last) begin
                            state      <= RESP;
                            mem_valid  <= 1'b0;
                            mem_mode   <= 1'b0;
                            mem_addr   <= '0;
                            mem_w_data <= 8'd0;
                            resp_valid <= 1'b1;
                        end
                        if (mem_invalid_addr) begin
                            rbuf       <= 64'd0;
                            resp_err   <= 1'b1;
                            resp_rdata <= 64'd0;
                        end else if (last) begin
                            rbuf       <= rbuf_next;
                            resp_rdata <= we ? 64'd0 : extend(rbuf_next, size, sgn);
                        end else begin
                            rbuf       <= rbuf_next;
                            cnt        <= cnt + 3'd1;
                            wbuf       <= wbuf >> 8;
                            mem_addr   <= mem_addr + ADDR_W'(1);
                            mem_w_data <= wbuf[15:8];
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        cnt        <= 3'd0;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= 64'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_bridge.sv
// Directed bench for lsu_byte_bridge with a small byte-wide memory model:
// 64 KiB RAM at 0x0000_8000_0000_0000, a character port at 0x1000, a stop port at 0x2000.
module tb_lsu_byte_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_mode;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [63:0] mem_addr;
    logic [7:0]  mem_w_data;
    logic        mem_r_data_valid;
    logic [7:0]  mem_r_data;
    logic        mem_invalid_addr;

    int checks = 0;
    int errors = 0;

    lsu_byte_bridge #(.ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_mode(mem_mode), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_r_data_valid(mem_r_data_valid), .mem_r_data(mem_r_data),
        .mem_invalid_addr(mem_invalid_addr)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram [0:65535];
    logic        in_ram;
    logic        addr_ok;
    logic [7:0]  uart_char = 8'd0;
    logic        stop_flag = 1'b0;
    int          beat_count = 0;
    logic [63:0] log_addr [0:255];
    logic [7:0]  log_data [0:255];
    logic        log_mode [0:255];

    always_comb begin
        in_ram           = (mem_addr[63:16] == 48'h0000_8000_0000);
        addr_ok          = in_ram || mem_addr == 64'h1000 || mem_addr == 64'h2000;
        mem_invalid_addr = mem_valid && !addr_ok;
        mem_r_data_valid = mem_valid && !mem_mode && in_ram;
        mem_r_data       = in_ram ? ram[mem_addr[15:0]] : 8'h00;
    end

    // The memory shares the bridge reset, so a beat coinciding with reset is dropped.
    always @(posedge clk) begin
        if (!rst && mem_valid && mem_ready) begin
            log_addr[beat_count[7:0]] <= mem_addr;
            log_data[beat_count[7:0]] <= mem_w_data;
            log_mode[beat_count[7:0]] <= mem_mode;
            beat_count <= beat_count + 1;
            if (mem_mode && in_ram)
                ram[mem_addr[15:0]] <= mem_w_data;
            else if (mem_mode && mem_addr == 64'h1000) begin
                uart_char <= mem_w_data;
                $display("[TB] memory prints '%c'", mem_w_data);
            end else if (mem_mode && mem_addr == 64'h2000 && mem_w_data == 8'hFF)
                stop_flag <= 1'b1;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Issues one request with resp_ready held high; lat counts cycles from acceptance to resp_valid.
    task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [63:0] addr, input logic [63:0] wdata,
                                  output logic [63:0] rdata, output logic err,
                                  output int lat, output int nbeats, output int start);
        @(negedge clk);
        check_output("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        start = beat_count;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check_output("resp_timeout", 64'd0, 64'd1);
        rdata  = resp_rdata;
        err    = resp_err;
        nbeats = beat_count - start;
        @(negedge clk);
        check_output("back_to_idle", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] rdata;
        logic        err;
        int          lat, nbeats, start;
        logic [63:0] pat;
        logic [63:0] stall_addr [1:5];
        logic        stall_rdy  [1:5];

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check_output("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_output("rst_resp_rdata", resp_rdata, 64'd0);
        check_output("rst_resp_err", {63'd0, resp_err}, 64'd0);
        check_output("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        check_output("rst_mem_mode", {63'd0, mem_mode}, 64'd0);
        check_output("rst_mem_addr", mem_addr, 64'd0);
        check_output("rst_mem_w_data", {56'd0, mem_w_data}, 64'd0);

        pat = 64'h1122_3344_5566_7788;
        apply_stimulus(1'b1, 2'd3, 1'b0, 64'h0000_8000_0000_0010, pat, rdata, err, lat, nbeats, start);
        check_output("st8_beats", 64'(nbeats), 64'd8);
        check_output("st8_err", {63'd0, err}, 64'd0);
        check_output("st8_rdata", rdata, 64'd0);
        for (int i = 0; i < 8; i++) begin
            check_output("st8_addr", log_addr[start + i], 64'h0000_8000_0000_0010 + 64'(i));
            check_output("st8_data", {56'd0, log_data[start + i]}, {56'd0, pat[8*i +: 8]});
            check_output("st8_mode", {63'd0, log_mode[start + i]}, 64'd1);
        end

        apply_stimulus(1'b0, 2'd3, 1'b1, 64'h0000_8000_0000_0010, 64'd0, rdata, err, lat, nbeats, start);
        check_output("ld8_rdata", rdata, 64'h1122_3344_5566_7788);
        check_output("ld8_err", {63'd0, err}, 64'd0);
        check_output("ld8_latency", 64'(lat), 64'd9);
        check_output("ld8_beats", 64'(nbeats), 64'd8);
        check_output("ld8_mode", {63'd0, log_mode[start]}, 64'd0);

        apply_stimulus(1'b1, 2'd1, 1'b0, 64'h0000_8000_0000_0020, 64'hF234, rdata, err, lat, nbeats, start);
        apply_stimulus(1'b0, 2'd1, 1'b1, 64'h0000_8000_0000_0020, 64'd0, rdata, err, lat, nbeats, start);
        check_output("ld2_signed", rdata, 64'hFFFF_FFFF_FFFF_F234);
        check_output("ld2_latency", 64'(lat), 64'd3);
        apply_stimulus(1'b0, 2'd1, 1'b0, 64'h0000_8000_0000_0020, 64'd0, rdata, err, lat, nbeats, start);
        check_output("ld2_unsigned", rdata, 64'h0000_0000_0000_F234);
        apply_stimulus(1'b0, 2'd0, 1'b1, 64'h0000_8000_0000_0021, 64'd0, rdata, err, lat, nbeats, start);
        check_output("ld1_signed", rdata, 64'hFFFF_FFFF_FFFF_FFF2);

        apply_stimulus(1'b1, 2'd0, 1'b0, 64'h1000, 64'h41, rdata, err, lat, nbeats, start);
        check_output("uart_beats", 64'(nbeats), 64'd1);
        check_output("uart_err", {63'd0, err}, 64'd0);
        check_output("uart_char", {56'd0, uart_char}, 64'h41);
        apply_stimulus(1'b1, 2'd0, 1'b0, 64'h2000, 64'hFF, rdata, err, lat, nbeats, start);
        check_output("stop_flag", {63'd0, stop_flag}, 64'd1);

        apply_stimulus(1'b0, 2'd2, 1'b0, 64'h0, 64'd0, rdata, err, lat, nbeats, start);
        check_output("inv_err", {63'd0, err}, 64'd1);
        check_output("inv_rdata", rdata, 64'd0);
        check_output("inv_beats", 64'(nbeats), 64'd1);
        check_output("inv_latency", 64'(lat), 64'd2);

        // Unaligned load crossing out of RAM with alternating stalls and a slow response consumer.
        stall_addr[1] = 64'h0000_8000_0000_FFFE; stall_rdy[1] = 1'b1;
        stall_addr[2] = 64'h0000_8000_0000_FFFF; stall_rdy[2] = 1'b0;
        stall_addr[3] = 64'h0000_8000_0000_FFFF; stall_rdy[3] = 1'b1;
        stall_addr[4] = 64'h0000_8000_0001_0000; stall_rdy[4] = 1'b0;
        stall_addr[5] = 64'h0000_8000_0001_0000; stall_rdy[5] = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 64'h0000_8000_0000_FFFE;
        start = beat_count;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_ready = stall_rdy[c];
            check_output("stall_mem_valid", {63'd0, mem_valid}, 64'd1);
            check_output("stall_mem_addr", mem_addr, stall_addr[c]);
            check_output("stall_req_ready", {63'd0, req_ready}, 64'd0);
        end
        for (int c = 6; c <= 8; c++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            check_output("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
            check_output("hold_resp_err", {63'd0, resp_err}, 64'd1);
            check_output("hold_resp_rdata", resp_rdata, 64'd0);
            check_output("hold_mem_valid", {63'd0, mem_valid}, 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check_output("stall_done_resp", {63'd0, resp_valid}, 64'd0);
        check_output("stall_done_ready", {63'd0, req_ready}, 64'd1);
        check_output("stall_beats", 64'(beat_count - start), 64'd3);

        apply_stimulus(1'b1, 2'd3, 1'b0, 64'h0000_8000_0000_0040, 64'd0, rdata, err, lat, nbeats, start);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3;
        req_addr = 64'h0000_8000_0000_0040; req_wdata = 64'h0102_0304_0506_A5C3;
        start = beat_count;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("abort_beat2_addr", mem_addr, 64'h0000_8000_0000_0042);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_mem_valid", {63'd0, mem_valid}, 64'd0);
        check_output("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_output("abort_req_ready", {63'd0, req_ready}, 64'd1);
        repeat (3) @(negedge clk);
        check_output("abort_no_beats", 64'(beat_count - start), 64'd2);
        check_output("abort_byte0", {56'd0, ram[16'h0040]}, 64'hC3);
        check_output("abort_byte1", {56'd0, ram[16'h0041]}, 64'hA5);
        check_output("abort_byte2", {56'd0, ram[16'h0042]}, 64'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
